// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: frames one (A, B, op) request onto the ALU serial input
// with CRC4 protection, then deserializes and checks the ALU response frames
// and returns result, flags, error payload or failure kind over valid/ready.
module alu_serial_ctrl #(
   parameter int BIT_DIV = 1,
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [2:0]  req_op,
   input  logic        req_bad_crc,
   output logic        sin,
   input  logic        sout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_c,
   output logic [3:0]  rsp_flags,
   output logic [7:0]  rsp_status,
   output logic [1:0]  rsp_kind,
   output logic        busy
);

   localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [1:0] K_OK = 2'b00, K_ERR = 2'b01, K_TO = 2'b10, K_INT = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_RESP} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] div_cnt;
   logic [3:0]    bit_cnt;
   logic [3:0]    frame_cnt;
   logic [TW-1:0] to_cnt;
   logic          hunting;
   logic [98:0]   tx_sh;
   logic [8:0]    rx_sh;
   logic [31:0]   c_acc;
   logic [1:0]    fin_kind;
   logic [7:0]    rx_pl;
   logic          accept, div_done, send_last, rx_sample, rx_stop, rx_type, crc3_ok;

   function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
      logic [3:0] c;
      logic       fb;
      c = 4'd0;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ msg[i];
         c  = {c[2], c[1], c[0] ^ fb, fb};
      end
      return c;
   endfunction

   function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
      logic [2:0] c;
      logic       fb;
      c = 3'd0;
      for (int i = 36; i >= 0; i--) begin
         fb = c[2] ^ msg[i];
         c  = {c[1], c[0] ^ fb, fb};
      end
      return c;
   endfunction

   function automatic logic [10:0] frame(input logic typ, input logic [7:0] pl);
      return {1'b0, typ, pl, 1'b1};
   endfunction

   function automatic logic [98:0] build_req(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op, input logic bad);
      logic [3:0] crc;
      crc = crc4_calc({b, a, 1'b1, op});
      if (bad) crc = ~crc;
      return {frame(1'b0, b[31:24]), frame(1'b0, b[23:16]), frame(1'b0, b[15:8]),
              frame(1'b0, b[7:0]), frame(1'b0, a[31:24]), frame(1'b0, a[23:16]),
              frame(1'b0, a[15:8]), frame(1'b0, a[7:0]), frame(1'b1, {1'b0, op, crc})};
   endfunction

   assign accept    = req_valid & req_ready;
   assign div_done  = (div_cnt == DIV_LAST);
   assign send_last = (state == S_SEND) && div_done && (bit_cnt == 4'd10) && (frame_cnt == 4'd8);
   assign rx_sample = (state == S_RECV) && !hunting && div_done;
   assign rx_stop   = rx_sample && (bit_cnt == 4'd10);
   assign rx_type   = rx_sh[8];
   assign rx_pl     = rx_sh[7:0];
   assign crc3_ok   = (crc3_calc({c_acc, 1'b0, rx_pl[6:3]}) == rx_pl[2:0]);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode, response classification and control outputs
   always_comb begin
      state_nxt = state;
      fin_kind  = K_OK;
      req_ready = (state == S_IDLE) && rst_n;
      busy      = (state != S_IDLE);
      rsp_valid = (state == S_RESP);
      sin       = 1'b1;
      case (state)
         S_IDLE: if (accept) state_nxt = S_SEND;
         S_SEND: begin
            sin = tx_sh[98];
            if (send_last) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!sout) begin
               state_nxt = S_RECV;
            end else if (to_cnt == TO_LAST) begin
               state_nxt = S_RESP;
               fin_kind  = K_TO;
            end
         end
         S_RECV: begin
            if (rx_stop) begin
               if (!sout) begin
                  state_nxt = S_RESP;
                  fin_kind  = K_INT;
               end else if (frame_cnt == 4'd0 && rx_type) begin
                  state_nxt = S_RESP;
                  fin_kind  = K_ERR;
               end else if (frame_cnt == 4'd4) begin
                  state_nxt = S_RESP;
                  fin_kind  = (rx_type && crc3_ok) ? K_OK : K_INT;
               end else if (rx_type) begin
                  state_nxt = S_RESP;
                  fin_kind  = K_INT;
               end
            end
         end
         S_RESP: if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bit-period, bit, frame and timeout counters; cleared on every state change
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         bit_cnt   <= 4'd0;
         frame_cnt <= 4'd0;
         to_cnt    <= '0;
         hunting   <= 1'b0;
      end else if (state_nxt != state) begin
         div_cnt   <= '0;
         to_cnt    <= '0;
         frame_cnt <= 4'd0;
         hunting   <= 1'b0;
         // entering RECV: the start bit was just seen, next sample is bit 1
         bit_cnt   <= (state_nxt == S_RECV) ? 4'd1 : 4'd0;
      end else begin
         case (state)
            S_SEND: begin
               if (div_done) begin
                  div_cnt <= '0;
                  if (bit_cnt == 4'd10) begin
                     bit_cnt   <= 4'd0;
                     frame_cnt <= frame_cnt + 4'd1;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            S_WAIT: to_cnt <= to_cnt + TW'(1);
            S_RECV: begin
               if (hunting) begin
                  // between response frames: wait for the next start bit
                  if (!sout) begin
                     hunting <= 1'b0;
                     bit_cnt <= 4'd1;
                     div_cnt <= '0;
                  end
               end else if (div_done) begin
                  div_cnt <= '0;
                  if (bit_cnt == 4'd10) begin
                     hunting   <= 1'b1;
                     bit_cnt   <= 4'd0;
                     frame_cnt <= frame_cnt + 4'd1;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Transmit shift register: loaded with all nine frames at accept, MSB out first
   always_ff @(posedge clk) begin
      if (accept)                          tx_sh <= build_req(req_a, req_b, req_op, req_bad_crc);
      else if (state == S_SEND && div_done) tx_sh <= {tx_sh[97:0], 1'b1};
   end

   // Receive shift register (type + payload) and result byte accumulator
   always_ff @(posedge clk) begin
      if (rx_sample && (bit_cnt != 4'd10)) rx_sh <= {rx_sh[7:0], sout};
      if (rx_stop && sout && !rx_type && (frame_cnt < 4'd4)) c_acc <= {c_acc[23:0], rx_pl};
   end

   // Response registers: captured on entry to RESP, cleared on handshake
   always_ff @(posedge clk) begin
      if (!rst_n || (state == S_RESP && rsp_ready)) begin
         rsp_c      <= 32'd0;
         rsp_flags  <= 4'd0;
         rsp_status <= 8'd0;
         rsp_kind   <= K_OK;
      end else if (state != S_RESP && state_nxt == S_RESP) begin
         rsp_kind   <= fin_kind;
         rsp_c      <= (fin_kind == K_OK)  ? c_acc      : 32'd0;
         rsp_flags  <= (fin_kind == K_OK)  ? rx_pl[6:3] : 4'd0;
         rsp_status <= (fin_kind == K_ERR) ? rx_pl      : 8'd0;
      end
   end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: two instances (BIT_DIV=1 and BIT_DIV=4), a
// directed vector table plus hand sequences for hold, timeout and mid-send reset.
module tb_alu_serial_ctrl;

   localparam int TMO = 50;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic        bad;
      int          mode;   // 0 data, 1 error frame, 2 silent, 3 crc3 flip, 4 stop0, 5 early ctl, 6 late data
      logic [31:0] rc;
      logic [3:0]  rf;
      logic [7:0]  rs;
      int          gap;
      logic [1:0]  ek;
      logic [31:0] ec;
      logic [3:0]  ef;
      logic [7:0]  es;
   } vec_t;

   logic        clk, rst_n;
   logic [1:0]  req_valid, req_ready, sin, sout, rsp_valid, rsp_ready, busy;
   logic [31:0] req_a, req_b;
   logic [2:0]  req_op;
   logic        req_bad_crc;
   logic [31:0] rsp_c [2];
   logic [3:0]  rsp_flags [2];
   logic [7:0]  rsp_status [2];
   logic [1:0]  rsp_kind [2];

   int n_pass, n_tot;
   vec_t vt [10];

   alu_serial_ctrl #(.BIT_DIV(1), .TIMEOUT(TMO)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_bad_crc(req_bad_crc),
      .sin(sin[0]), .sout(sout[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_c(rsp_c[0]), .rsp_flags(rsp_flags[0]), .rsp_status(rsp_status[0]),
      .rsp_kind(rsp_kind[0]), .busy(busy[0]));

   alu_serial_ctrl #(.BIT_DIV(4), .TIMEOUT(TMO)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_bad_crc(req_bad_crc),
      .sin(sin[1]), .sout(sout[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_c(rsp_c[1]), .rsp_flags(rsp_flags[1]), .rsp_status(rsp_status[1]),
      .rsp_kind(rsp_kind[1]), .busy(busy[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Remainder of msg*x^4 divided by x^4+x+1
   function automatic logic [3:0] crc4_div(input logic [67:0] m);
      logic [71:0] r;
      r = {m, 4'b0000};
      for (int i = 71; i >= 4; i--)
         if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
      return r[3:0];
   endfunction

   // Remainder of msg*x^3 divided by x^3+x+1
   function automatic logic [2:0] crc3_div(input logic [36:0] m);
      logic [39:0] r;
      r = {m, 3'b000};
      for (int i = 39; i >= 3; i--)
         if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
      return r[2:0];
   endfunction

   function automatic logic [98:0] exp_frames(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op, input logic bad);
      logic [63:0] ops;
      logic [3:0]  c;
      logic [98:0] f;
      ops = {b, a};
      c = crc4_div({b, a, 1'b1, op});
      if (bad) c = ~c;
      f = '0;
      for (int i = 0; i < 8; i++) f = {f[87:0], 2'b00, ops[63 - 8*i -: 8], 1'b1};
      f = {f[87:0], 1'b0, 1'b1, 1'b0, op, c, 1'b1};
      return f;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_request(input int d, input vec_t v, input string tag);
      int dv, n, errs;
      logic [98:0] ef;
      dv = (d == 0) ? 1 : 4;
      ef = exp_frames(v.a, v.b, v.op, v.bad);
      @(negedge clk);
      req_a = v.a; req_b = v.b; req_op = v.op; req_bad_crc = v.bad;
      req_valid[d] = 1'b1;
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
      @(negedge clk);
      req_valid[d] = 1'b0;
      errs = 0;
      for (int k = 0; k < 99 * dv; k++) begin
         if (sin[d] !== ef[98 - k/dv] || req_ready[d] !== 1'b0 || busy[d] !== 1'b1) errs++;
         @(negedge clk);
      end
      chk({tag, "_sin_frames_errs"}, 32'(errs), 32'd0);
      chk({tag, "_sin_idle_after_send"}, 32'(sin[d]), 32'd1);
   endtask

   task automatic drive_frame(input int d, input logic typ, input logic [7:0] pl, input logic stopb);
      logic [10:0] f;
      int dv;
      dv = (d == 0) ? 1 : 4;
      f = {1'b0, typ, pl, stopb};
      for (int k = 10; k >= 0; k--) begin
         sout[d] = f[k];
         repeat (dv) @(negedge clk);
      end
      sout[d] = 1'b1;
   endtask

   task automatic drive_resp(input int d, input vec_t v);
      logic [2:0] crc;
      case (v.mode)
         0, 3: begin
            crc = crc3_div({v.rc, 1'b0, v.rf});
            if (v.mode == 3) crc = crc ^ 3'b010;
            for (int i = 0; i < 4; i++) begin
               drive_frame(d, 1'b0, v.rc[31 - 8*i -: 8], 1'b1);
               repeat (v.gap) @(negedge clk);
            end
            drive_frame(d, 1'b1, {1'b0, v.rf, crc}, 1'b1);
         end
         1: drive_frame(d, 1'b1, v.rs, 1'b1);
         4: begin
            drive_frame(d, 1'b0, 8'h12, 1'b1);
            drive_frame(d, 1'b0, 8'h34, 1'b0);
         end
         5: begin
            drive_frame(d, 1'b0, 8'h11, 1'b1);
            drive_frame(d, 1'b0, 8'h22, 1'b1);
            drive_frame(d, 1'b1, 8'h00, 1'b1);
         end
         6: for (int i = 0; i < 5; i++) drive_frame(d, 1'b0, 8'h5A, 1'b1);
         default: ;
      endcase
   endtask

   task automatic wait_rsp(input int d, input int lim, output int n);
      n = 0;
      while (rsp_valid[d] !== 1'b1 && n < lim) begin @(negedge clk); n++; end
   endtask

   task automatic check_rsp(input int d, input vec_t v, input string tag);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
      chk({tag, "_kind"}, 32'(rsp_kind[d]), 32'(v.ek));
      chk({tag, "_c"}, rsp_c[d], v.ec);
      chk({tag, "_flags"}, 32'(rsp_flags[d]), 32'(v.ef));
      chk({tag, "_status"}, 32'(rsp_status[d]), 32'(v.es));
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      chk({tag, "_valid_drop"}, 32'(rsp_valid[d]), 32'd0);
      chk({tag, "_ready_back"}, 32'(req_ready[d]), 32'd1);
      chk({tag, "_busy_clear"}, 32'(busy[d]), 32'd0);
   endtask

   task automatic run_vec(input int d, input vec_t v, input string tag);
      int n;
      do_request(d, v, tag);
      if (v.mode == 2) begin
         wait_rsp(d, 200, n);
         chk({tag, "_timeout_latency"}, 32'(n), 32'(TMO));
      end else begin
         repeat (3) @(negedge clk);
         drive_resp(d, v);
         wait_rsp(d, 50, n);
      end
      check_rsp(d, v, tag);
   endtask

   initial begin
      vec_t hv;
      int   n, errs;
      n_pass = 0; n_tot = 0;
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; sout = 2'b11;
      req_a = 32'd0; req_b = 32'd0; req_op = 3'd0; req_bad_crc = 1'b0;

      vt[0] = '{32'd1, 32'd2, 3'd0, 1'b0, 0, 32'd3, 4'h0, 8'h00, 0, 2'd0, 32'd3, 4'h0, 8'h00};
      vt[1] = '{32'd0, 32'd0, 3'd2, 1'b0, 0, 32'd0, 4'b0010, 8'h00, 0, 2'd0, 32'd0, 4'b0010, 8'h00};
      vt[2] = '{32'h1111_2222, 32'h3333_4444, 3'd1, 1'b1, 1, 32'd0, 4'h0, 8'hA5, 0, 2'd1, 32'd0, 4'h0, 8'hA5};
      vt[3] = '{32'h5, 32'h7, 3'd0, 1'b0, 2, 32'd0, 4'h0, 8'h00, 0, 2'd2, 32'd0, 4'h0, 8'h00};
      vt[4] = '{32'h9, 32'h7, 3'd0, 1'b0, 3, 32'h10, 4'b0001, 8'h00, 0, 2'd3, 32'd0, 4'h0, 8'h00};
      vt[5] = '{32'hA, 32'hB, 3'd3, 1'b0, 4, 32'd0, 4'h0, 8'h00, 0, 2'd3, 32'd0, 4'h0, 8'h00};
      vt[6] = '{32'hDEAD_BEEF, 32'h1234_5678, 3'd7, 1'b0, 0, 32'hCAFE_F00D, 4'b1001, 8'h00, 2, 2'd0, 32'hCAFE_F00D, 4'b1001, 8'h00};
      vt[7] = '{32'h1, 32'h1, 3'd4, 1'b0, 5, 32'd0, 4'h0, 8'h00, 0, 2'd3, 32'd0, 4'h0, 8'h00};
      vt[8] = '{32'h2, 32'h2, 3'd5, 1'b0, 6, 32'd0, 4'h0, 8'h00, 0, 2'd3, 32'd0, 4'h0, 8'h00};
      vt[9] = '{32'h8000_0000, 32'h8000_0000, 3'd0, 1'b0, 0, 32'd0, 4'b0110, 8'h00, 1, 2'd0, 32'd0, 4'b0110, 8'h00};

      // reset state
      @(negedge clk);
      chk("rst_sin", 32'(sin[0]), 32'd1);
      chk("rst_req_ready", 32'(req_ready[0]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_rsp_c", rsp_c[0], 32'd0);
      chk("rst_kind", 32'(rsp_kind[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 32'(req_ready[0]), 32'd1);

      for (int i = 0; i < 10; i++) run_vec(0, vt[i], $sformatf("vec%0d", i));

      // slower bit rate: data response and bare timeout
      run_vec(1, vt[1], "div4_data");
      run_vec(1, vt[3], "div4_timeout");

      // response held while rsp_ready stays low, new request refused
      hv = '{32'h4, 32'h4, 3'd1, 1'b0, 0, 32'h0F0F_0F0F, 4'b1000, 8'h00, 0, 2'd0, 32'h0F0F_0F0F, 4'b1000, 8'h00};
      do_request(0, hv, "hold");
      repeat (3) @(negedge clk);
      drive_resp(0, hv);
      wait_rsp(0, 50, n);
      req_valid[0] = 1'b1;
      errs = 0;
      for (int k = 0; k < 20; k++) begin
         if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 || sin[0] !== 1'b1 ||
             rsp_c[0] !== 32'h0F0F_0F0F || rsp_flags[0] !== 4'b1000 || rsp_kind[0] !== 2'b00) errs++;
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      chk("hold_stable_errs", 32'(errs), 32'd0);
      check_rsp(0, hv, "hold");

      // reset in the middle of SEND
      @(negedge clk);
      req_a = 32'hFFFF_FFFF; req_b = 32'h0; req_op = 3'd0; req_bad_crc = 1'b0;
      req_valid[0] = 1'b1;
      @(negedge clk);
      req_valid[0] = 1'b0;
      repeat (30) @(negedge clk);
      chk("midrst_busy_before", 32'(busy[0]), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_sin", 32'(sin[0]), 32'd1);
      chk("midrst_busy", 32'(busy[0]), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("midrst_req_ready", 32'(req_ready[0]), 32'd0);
      rst_n = 1'b1;
      errs = 0;
      for (int k = 0; k < 150; k++) begin
         if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0 || sin[0] !== 1'b1) errs++;
         @(negedge clk);
      end
      chk("midrst_quiet_errs", 32'(errs), 32'd0);
      run_vec(0, vt[0], "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
